// File: rtl/sd_pkg.sv
// sd_pkg: shared types and constants for the SD CMD-line controller
package sd_pkg;
  localparam int CMD_FRAME_BITS = 48;
  localparam int CRC_BITS = 7;
  localparam int PAYLOAD_BITS = CMD_FRAME_BITS - CRC_BITS - 1;
  typedef enum logic [2:0] {S_IDLE, S_SEND, S_TURN, S_RECV, S_GAP, S_DONE} state_e;
  typedef enum logic [1:0] {ST_OK = 2'b00, ST_TIMEOUT = 2'b01, ST_CRC_ERR = 2'b10, ST_FRAME_ERR = 2'b11} status_e;
  typedef enum logic [1:0] {RT_NONE = 2'b00, RT_CRC = 2'b01, RT_NOCRC = 2'b10, RT_CRC_ALT = 2'b11} resp_e;
  function automatic logic [5:0] sat_inc(input logic [5:0] v);
    return &v ? v : v + 6'd1;
  endfunction
endpackage

// File: rtl/sd_crc7.sv
// sd_crc7: serial CRC7 (x^7+x^3+1), MSB first, zero-initialised by a synchronous clear
module sd_crc7
  import sd_pkg::*;
(
  input  logic                clk,
  input  logic                n_rst,
  input  logic                clr,
  input  logic                en,
  input  logic                din,
  output logic [CRC_BITS-1:0] crc
);
  logic [CRC_BITS-1:0] crc_q, crc_d;
  logic fb;
  always_comb begin
    fb = din ^ crc_q[6];
    crc_d = clr ? '0 : en ? {crc_q[5:3], crc_q[2] ^ fb, crc_q[1:0], fb} : crc_q;
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) crc_q <= '0;
    else crc_q <= crc_d;
  assign crc = crc_q;
endmodule

// File: rtl/sd_cmd_ctrl.sv
// sd_cmd_ctrl: sequences one SD CMD-line transaction in 1-bit mode;
// sends a 48-bit command with CRC7 and optionally captures a 48-bit response.
module sd_cmd_ctrl
  import sd_pkg::*;
#(
  parameter int TIMEOUT_BITS = 64,
  parameter int GAP_BITS = 8
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [1:0]  resp_type,
  input  logic        abort,
  input  logic        shift_tick,
  output logic        timer_enable,
  output logic        timer_clear,
  input  logic        cmd_in,
  output logic        cmd_out,
  output logic        cmd_oe,
  output logic        done,
  output logic [1:0]  status,
  output logic [5:0]  resp_index,
  output logic [31:0] resp_arg
);
  state_e state_q, state_d;
  status_e status_q, status_d;
  resp_e rtype_q, rtype_d;
  logic [PAYLOAD_BITS-1:0] tx_q, tx_d;
  logic [CMD_FRAME_BITS-3:0] rx_q, rx_d;
  logic [5:0] cnt_q, cnt_d;
  logic [5:0] resp_index_q, resp_index_d;
  logic [31:0] resp_arg_q, resp_arg_d;
  logic timer_clear_q, timer_clear_d;
  logic accept, tick, send_bit, frame_err, crc_err;
  logic [CRC_BITS-1:0] crc_tx, crc_rx;

  assign accept = state_q == S_IDLE && req_valid;
  // The timer is restarting while timer_clear is high, so a tick then is not a bit boundary
  assign tick = shift_tick && !timer_clear_q && !abort;
  assign send_bit = cnt_q < 6'(PAYLOAD_BITS) ? tx_q[PAYLOAD_BITS-1]
                  : cnt_q < 6'(CMD_FRAME_BITS - 1) ? crc_tx[3'(6'(CMD_FRAME_BITS - 2) - cnt_q)]
                  : 1'b1;
  // rx_q[i] holds response bit i+1; bit 0 is still on cmd_in at the final tick
  assign frame_err = rx_q[45] || !cmd_in;
  assign crc_err = rtype_q != RT_NOCRC && rx_q[6:0] != crc_rx;

  sd_crc7 u_crc_tx (
    .clk,
    .n_rst,
    .clr(accept),
    .en(state_q == S_SEND && tick && cnt_q < 6'(PAYLOAD_BITS)),
    .din(tx_q[PAYLOAD_BITS-1]),
    .crc(crc_tx)
  );

  sd_crc7 u_crc_rx (
    .clk,
    .n_rst,
    .clr(accept),
    .en(tick && ((state_q == S_TURN && !cmd_in) || (state_q == S_RECV && cnt_q < 6'(PAYLOAD_BITS)))),
    .din(cmd_in),
    .crc(crc_rx)
  );

  always_comb begin
    state_d = state_q;
    status_d = status_q;
    rtype_d = rtype_q;
    tx_d = tx_q;
    rx_d = rx_q;
    cnt_d = cnt_q;
    resp_index_d = resp_index_q;
    resp_arg_d = resp_arg_q;
    timer_clear_d = 1'b0;
    if (state_q != S_IDLE && abort) state_d = S_IDLE;
    else case (state_q)
      S_IDLE: if (req_valid) begin
        state_d = S_SEND;
        status_d = ST_OK;
        rtype_d = resp_e'(resp_type);
        tx_d = {2'b01, cmd_index, cmd_arg};
        cnt_d = '0;
        timer_clear_d = 1'b1;
      end
      S_SEND: if (tick) begin
        tx_d = {tx_q[PAYLOAD_BITS-2:0], 1'b0};
        cnt_d = sat_inc(cnt_q);
        if (cnt_q == 6'(CMD_FRAME_BITS - 1)) begin
          state_d = rtype_q == RT_NONE ? S_GAP : S_TURN;
          cnt_d = '0;
        end
      end
      S_TURN: if (tick) begin
        if (!cmd_in) begin
          state_d = S_RECV;
          cnt_d = 6'd1;
        end else if (cnt_q == 6'(TIMEOUT_BITS - 1)) begin
          state_d = S_GAP;
          status_d = ST_TIMEOUT;
          cnt_d = '0;
        end else cnt_d = sat_inc(cnt_q);
      end
      S_RECV: if (tick) begin
        rx_d = {rx_q[CMD_FRAME_BITS-4:0], cmd_in};
        cnt_d = sat_inc(cnt_q);
        if (cnt_q == 6'(CMD_FRAME_BITS - 1)) begin
          state_d = S_GAP;
          status_d = frame_err ? ST_FRAME_ERR : crc_err ? ST_CRC_ERR : ST_OK;
          resp_index_d = rx_q[44:39];
          resp_arg_d = rx_q[38:7];
          cnt_d = '0;
        end
      end
      S_GAP: if (tick) begin
        cnt_d = sat_inc(cnt_q);
        if (cnt_q == 6'(GAP_BITS - 1)) begin
          state_d = S_DONE;
          cnt_d = '0;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state_q <= S_IDLE;
      status_q <= ST_OK;
      rtype_q <= RT_NONE;
      tx_q <= '0;
      rx_q <= '0;
      cnt_q <= '0;
      resp_index_q <= '0;
      resp_arg_q <= '0;
      timer_clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      status_q <= status_d;
      rtype_q <= rtype_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      cnt_q <= cnt_d;
      resp_index_q <= resp_index_d;
      resp_arg_q <= resp_arg_d;
      timer_clear_q <= timer_clear_d;
    end

  assign req_ready = state_q == S_IDLE;
  assign cmd_oe = state_q inside {S_SEND, S_GAP};
  assign cmd_out = state_q == S_SEND ? send_bit : 1'b1;
  assign timer_enable = state_q inside {S_SEND, S_TURN, S_RECV, S_GAP};
  assign timer_clear = timer_clear_q;
  assign done = state_q == S_DONE;
  assign status = status_q;
  assign resp_index = resp_index_q;
  assign resp_arg = resp_arg_q;
endmodule

// File: tb/tb_sd_cmd_ctrl.sv
// tb_sd_cmd_ctrl: directed and randomised transactions against a frame-level
// card and controller model; the bench drives shift_tick itself.
module tb_sd_cmd_ctrl;
  logic clk = 1'b0, n_rst = 1'b0, req_valid = 1'b0, abort = 1'b0, shift_tick = 1'b0, cmd_in = 1'b1;
  logic [5:0] cmd_index = '0;
  logic [31:0] cmd_arg = '0;
  logic [1:0] resp_type = '0;
  logic req_ready, timer_enable, timer_clear, cmd_out, cmd_oe, done;
  logic [1:0] status;
  logic [5:0] resp_index;
  logic [31:0] resp_arg;
  logic [45:0] outs;
  localparam logic [45:0] RST_VAL = {1'b1, 1'b0, 1'b1, 3'b000, 2'b00, 6'd0, 32'd0};

  int tests = 0, fails = 0, done_cnt = 0;
  int card_pre, dticks, send_oe, drive_hi, drive_any, extra_done, d0, mode;
  logic [47:0] card_resp, sent, rr;
  logic [5:0] m_idx = '0, ri;
  logic [31:0] m_arg = '0, ra;
  logic [1:0] rt;
  logic done_te;

  always #5 clk = ~clk;
  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;
  assign outs = {req_ready, cmd_oe, cmd_out, timer_enable, timer_clear, done, status, resp_index, resp_arg};

  sd_cmd_ctrl dut (
    .clk(clk), .n_rst(n_rst), .req_valid(req_valid), .req_ready(req_ready),
    .cmd_index(cmd_index), .cmd_arg(cmd_arg), .resp_type(resp_type), .abort(abort),
    .shift_tick(shift_tick), .timer_enable(timer_enable), .timer_clear(timer_clear),
    .cmd_in(cmd_in), .cmd_out(cmd_out), .cmd_oe(cmd_oe), .done(done), .status(status),
    .resp_index(resp_index), .resp_arg(resp_arg)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic f;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      f = d[i] ^ c[6];
      c = {c[5:0], 1'b0} ^ (f ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  function automatic logic [47:0] cmd_frame(input logic [5:0] i, input logic [31:0] a);
    return {2'b01, i, a, crc7({2'b01, i, a}), 1'b1};
  endfunction

  function automatic logic [47:0] good_resp(input logic [5:0] i, input logic [31:0] a);
    return {2'b00, i, a, crc7({2'b00, i, a}), 1'b1};
  endfunction

  function automatic logic [1:0] exp_status(input logic [47:0] r, input logic [1:0] t);
    if (r[46] || !r[0]) return 2'b11;
    if (t != 2'b10 && r[7:1] != crc7(r[47:8])) return 2'b10;
    return 2'b00;
  endfunction

  // Card: silent during the command, then card_pre idle-high bits, then the response
  function automatic logic card_bit(input int k, input logic [1:0] t);
    int r;
    r = k - 48;
    if (t == 2'b00 || r <= card_pre || r > card_pre + 48) return 1'b1;
    return card_resp[48 + card_pre - r];
  endfunction

  task automatic run(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] t, input bit hold, input int stop_at);
    sent = '0; dticks = 0; send_oe = 0; drive_hi = 0; drive_any = 0; extra_done = 0; done_te = 1'b1;
    @(negedge clk);
    cmd_index = idx; cmd_arg = arg; resp_type = t; req_valid = 1'b1; shift_tick = 1'b1;
    @(negedge clk);
    shift_tick = 1'b0; req_valid = hold; cmd_index = ~idx; cmd_arg = ~arg; resp_type = ~t;
    chk("accept", 64'({req_ready, timer_enable, timer_clear, cmd_oe}), 64'(4'b0111));
    @(negedge clk);
    for (int k = 1; k <= 250; k++) begin
      if (k == 40) req_valid = 1'b0;
      cmd_in = card_bit(k, t);
      shift_tick = 1'b1;
      if (k <= 48) begin
        sent = {sent[46:0], cmd_out};
        send_oe += int'(cmd_oe);
      end else begin
        drive_hi += int'(cmd_oe & cmd_out);
        drive_any += int'(cmd_oe);
      end
      @(negedge clk);
      shift_tick = 1'b0;
      if (done) begin
        dticks = k;
        done_te = timer_enable;
      end
      @(negedge clk);
      if (dticks != 0) begin
        extra_done = int'(done);
        break;
      end
      if (k == stop_at) break;
    end
    cmd_in = 1'b1;
  endtask

  task automatic verify(input string tag, input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] t);
    int et;
    logic [1:0] es;
    et = 56;
    es = 2'b00;
    if (t != 2'b00 && card_pre >= 64) begin
      et = 120;
      es = 2'b01;
    end else if (t != 2'b00) begin
      et = 104 + card_pre;
      es = exp_status(card_resp, t);
      m_idx = card_resp[45:40];
      m_arg = card_resp[39:8];
    end
    chk({tag, ".frame"}, 64'(sent), 64'(cmd_frame(idx, arg)));
    chk({tag, ".ticks"}, 64'(dticks), 64'(et));
    chk({tag, ".status"}, 64'(status), 64'(es));
    chk({tag, ".resp"}, 64'({resp_index, resp_arg}), 64'({m_idx, m_arg}));
    chk({tag, ".drive"}, 64'({8'(send_oe), 8'(drive_hi), 8'(drive_any), 8'(extra_done), done_te}),
        64'({8'd48, 8'd8, 8'd8, 8'd0, 1'b0}));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_hold", 64'(outs), 64'(RST_VAL));
    n_rst = 1'b1;
    @(negedge clk);
    chk("reset_release", 64'(outs), 64'(RST_VAL));

    card_pre = 1000; card_resp = '1;
    run(6'd0, 32'd0, 2'b00, 1'b0, 0);
    verify("cmd0", 6'd0, 32'd0, 2'b00);
    chk("cmd0.const", 64'(sent), 64'h4000_0000_0095);

    card_pre = 5; card_resp = 48'h08_0000_01AA_13;
    run(6'd8, 32'h1AA, 2'b01, 1'b0, 0);
    verify("cmd8", 6'd8, 32'h1AA, 2'b01);
    chk("cmd8.const", 64'({status, resp_index, resp_arg}), 64'({2'b00, 6'h08, 32'h1AA}));

    card_resp = 48'h08_0000_01AA_15;
    run(6'd8, 32'h1AA, 2'b01, 1'b0, 0);
    verify("badcrc", 6'd8, 32'h1AA, 2'b01);
    chk("badcrc.const", 64'(status), 64'(2'b10));
    run(6'd8, 32'h1AA, 2'b10, 1'b0, 0);
    verify("nocrc", 6'd8, 32'h1AA, 2'b10);
    chk("nocrc.const", 64'(status), 64'(2'b00));

    card_pre = 1000;
    run(6'd55, 32'hDEAD_BEEF, 2'b11, 1'b0, 0);
    verify("timeout", 6'd55, 32'hDEAD_BEEF, 2'b11);
    chk("timeout.const", 64'({dticks, status}), 64'({32'd120, 2'b01}));

    @(negedge clk) abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    chk("abort_idle", 64'({req_ready, cmd_oe, timer_enable, status}), 64'({3'b100, 2'b01}));

    card_pre = 3; card_resp = 48'h08_0000_01AA_12;
    run(6'd8, 32'h1AA, 2'b01, 1'b0, 0);
    verify("frame_err", 6'd8, 32'h1AA, 2'b01);
    chk("frame_err.const", 64'(status), 64'(2'b11));

    card_pre = 2; card_resp = good_resp(6'd17, 32'h1234_5678);
    run(6'd17, 32'h0BAD_F00D, 2'b01, 1'b1, 0);
    verify("hold_valid", 6'd17, 32'h0BAD_F00D, 2'b01);

    d0 = done_cnt;
    run(6'h2A, 32'hCAFE_0001, 2'b01, 1'b0, 10);
    @(negedge clk);
    abort = 1'b1; shift_tick = 1'b1;
    @(negedge clk);
    abort = 1'b0; shift_tick = 1'b0;
    chk("abort_send", 64'({cmd_oe, cmd_out, req_ready, timer_enable, status}), 64'({4'b0110, 2'b00}));
    repeat (30) @(negedge clk);
    chk("abort_nodone", 64'(done_cnt - d0), 64'd0);

    for (int n = 0; n < 8; n++) begin
      ri = 6'($urandom); ra = $urandom; rt = 2'($urandom_range(0, 3)); mode = $urandom_range(0, 4);
      rr = good_resp(6'($urandom), $urandom);
      card_pre = $urandom_range(0, 12);
      if (mode == 1) rr = rr ^ (48'd1 << $urandom_range(1, 7));
      if (mode == 2) rr[0] = 1'b0;
      if (mode == 3) rr[46] = 1'b1;
      if (mode == 4) card_pre = 1000;
      card_resp = rr;
      run(ri, ra, rt, 1'b0, 0);
      verify($sformatf("rand%0d", n), ri, ra, rt);
    end

    card_pre = 5; card_resp = good_resp(6'd33, 32'h5555_AAAA);
    run(6'd2, 32'h0, 2'b01, 1'b0, 63);
    #2 n_rst = 1'b0;
    #1 chk("reset_recv", 64'(outs), 64'(RST_VAL));
    m_idx = '0; m_arg = '0;
    @(negedge clk) n_rst = 1'b1;
    run(6'd3, 32'h0000_0F0F, 2'b01, 1'b0, 0);
    verify("after_reset", 6'd3, 32'h0000_0F0F, 2'b01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
